// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32IF field bundles into 32-bit instruction words,
// rejects illegal bundles and queues accepted words toward the fetch path.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_opcode,
    input  logic [2:0]             in_funct3,
    input  logic [6:0]             in_funct7,
    input  logic [5:0]             in_rs1,
    input  logic [5:0]             in_rs2,
    input  logic [5:0]             in_rd,
    input  logic [31:0]            in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic                   err,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_FLW   = 7'h07;
    localparam logic [6:0] OP_FSW   = 7'h27;
    localparam logic [6:0] OP_FALU  = 7'h53;
    localparam logic [6:0] OP_CSR   = 7'h73;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_BAD
    } fmt_t;

    // Which register fields an opcode uses and which of them must be FP registers.
    typedef struct packed {
        fmt_t fmt;
        logic use_rd;
        logic use_rs1;
        logic use_rs2;
        logic fp_rd;
        logic fp_rs1;
        logic fp_rs2;
    } op_info_t;

    function automatic op_info_t op_info(input logic [6:0] op);
        op_info_t info;
        info.fmt     = FMT_BAD;
        info.use_rd  = 1'b0;
        info.use_rs1 = 1'b0;
        info.use_rs2 = 1'b0;
        info.fp_rd   = (op == OP_FLW) || (op == OP_FALU);
        info.fp_rs1  = (op == OP_FALU);
        info.fp_rs2  = (op == OP_FSW) || (op == OP_FALU);
        case (op)
            OP_R, OP_FALU: begin
                info.fmt     = FMT_R;
                info.use_rd  = 1'b1;
                info.use_rs1 = 1'b1;
                info.use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_FLW, OP_JALR: begin
                info.fmt     = FMT_I;
                info.use_rd  = 1'b1;
                info.use_rs1 = 1'b1;
            end
            OP_CSR: begin
                info.fmt     = FMT_CSR;
                info.use_rd  = 1'b1;
                info.use_rs1 = 1'b1;
            end
            OP_STORE, OP_FSW: begin
                info.fmt     = FMT_S;
                info.use_rs1 = 1'b1;
                info.use_rs2 = 1'b1;
            end
            OP_BR: begin
                info.fmt     = FMT_B;
                info.use_rs1 = 1'b1;
                info.use_rs2 = 1'b1;
            end
            OP_AUIPC, OP_LUI: begin
                info.fmt    = FMT_U;
                info.use_rd = 1'b1;
            end
            OP_JAL: begin
                info.fmt    = FMT_J;
                info.use_rd = 1'b1;
            end
            default: info.fmt = FMT_BAD;
        endcase
        return info;
    endfunction

    // The immediate must survive the truncation its format applies.
    function automatic logic imm_in_range(input fmt_t fmt, input logic signed [31:0] imm);
        logic ok;
        ok = 1'b0;
        case (fmt)
            FMT_R:        ok = 1'b1;
            FMT_I, FMT_S: ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
            FMT_CSR:      ok = (imm[31:12] == 20'd0);
            FMT_B:        ok = !imm[0] && (imm >= -32'sd4096) && (imm <= 32'sd4095);
            FMT_J:        ok = !imm[0] && (imm >= -32'sd1048576) && (imm <= 32'sd1048575);
            FMT_U:        ok = (imm[11:0] == 12'd0);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] pack_word(
        input fmt_t        fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = 32'd0;
        case (fmt)
            FMT_R:          w = {f7, rs2, rs1, f3, rd, op};
            FMT_I, FMT_CSR: w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:          w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:          w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:          w = {imm[31:12], rd, op};
            FMT_J:          w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:        w = 32'd0;
        endcase
        return w;
    endfunction

    op_info_t           info_p0;
    logic signed [31:0] imm_p0;
    logic               fp_ok_p0;
    logic               legal_p0;
    logic [31:0]        word_p0;
    logic               accept_p0;
    logic               push_p0;
    logic               reject_p0;
    logic               pop;
    logic               full;

    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    // Stage p0: combinational encode and legality check of the offered bundle.
    always_comb begin
        info_p0  = op_info(in_opcode);
        imm_p0   = in_imm;
        fp_ok_p0 = (!info_p0.use_rd  || (in_rd[5]  == info_p0.fp_rd))  &&
                   (!info_p0.use_rs1 || (in_rs1[5] == info_p0.fp_rs1)) &&
                   (!info_p0.use_rs2 || (in_rs2[5] == info_p0.fp_rs2));
        legal_p0 = (info_p0.fmt != FMT_BAD) && imm_in_range(info_p0.fmt, imm_p0) && fp_ok_p0;
        word_p0  = pack_word(info_p0.fmt, in_opcode, in_funct3, in_funct7,
                             in_rs1[4:0], in_rs2[4:0], in_rd[4:0], in_imm);
    end

    assign full      = (count == FULL_LVL);
    assign in_ready  = !full && !flush;
    assign accept_p0 = in_valid && in_ready;
    assign push_p0   = accept_p0 && legal_p0;
    assign reject_p0 = accept_p0 && !legal_p0;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem[rd_ptr] : 32'd0;
    assign level     = count;

    // Stage p1: FIFO storage, written only for legal accepted bundles.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            mem[wr_ptr] <= word_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= reject_p0;
            if (reject_p0 && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_p0) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push_p0, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: a queue-based reference model is compared
// against the DUT every cycle, plus directed cases with literal expectations.
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [5:0]  in_rs1;
    logic [5:0]  in_rs2;
    logic [5:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [ERR_W-1:0] err_cnt;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err(err), .err_cnt(err_cnt), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: legality from numeric ranges, word built from shifted fields.
    function automatic void model_encode(
        input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
        input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
        input logic [31:0] imm, output bit ok, output bit [31:0] w);
        int kind;
        bit urd, urs1, urs2, frd, frs1, frs2, rng;
        longint si;
        bit [31:0] o, r1, r2, rr, fn3, fn7, im;
        si = longint'($signed(imm));
        im = imm;
        o = 32'(op); r1 = 32'(rs1[4:0]); r2 = 32'(rs2[4:0]); rr = 32'(rd[4:0]);
        fn3 = 32'(f3); fn7 = 32'(f7);
        frd  = (op == 7'h07) || (op == 7'h53);
        frs2 = (op == 7'h27) || (op == 7'h53);
        frs1 = (op == 7'h53);
        urd = 0; urs1 = 0; urs2 = 0; rng = 0; w = 0;
        case (op)
            7'h33, 7'h53:               begin kind = 0; urd = 1; urs1 = 1; urs2 = 1; end
            7'h13, 7'h03, 7'h07, 7'h67: begin kind = 1; urd = 1; urs1 = 1; end
            7'h23, 7'h27:               begin kind = 2; urs1 = 1; urs2 = 1; end
            7'h63:                      begin kind = 3; urs1 = 1; urs2 = 1; end
            7'h37, 7'h17:               begin kind = 4; urd = 1; end
            7'h6F:                      begin kind = 5; urd = 1; end
            7'h73:                      begin kind = 6; urd = 1; urs1 = 1; end
            default:                    kind = -1;
        endcase
        case (kind)
            0: begin
                rng = 1;
                w = (fn7 << 25) | (r2 << 20) | (r1 << 15) | (fn3 << 12) | (rr << 7) | o;
            end
            1, 6: begin
                rng = (kind == 1) ? (si >= -2048 && si <= 2047) : (im <= 32'd4095);
                w = ((im & 32'hFFF) << 20) | (r1 << 15) | (fn3 << 12) | (rr << 7) | o;
            end
            2: begin
                rng = (si >= -2048 && si <= 2047);
                w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (fn3 << 12)
                    | ((im & 32'h1F) << 7) | o;
            end
            3: begin
                rng = (im[0] == 1'b0) && (si >= -4096 && si <= 4095);
                w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                    | (r1 << 15) | (fn3 << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 1) << 7) | o;
            end
            4: begin
                rng = ((im % 4096) == 0);
                w = (im & 32'hFFFFF000) | (rr << 7) | o;
            end
            5: begin
                rng = (im[0] == 1'b0) && (si >= -(64'sd1 <<< 20) && si <= (64'sd1 <<< 20) - 1);
                w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (rr << 7) | o;
            end
            default: rng = 0;
        endcase
        ok = (kind >= 0) && rng && (!urd || rd[5] == frd) && (!urs1 || rs1[5] == frs1)
             && (!urs2 || rs2[5] == frs2);
    endfunction

    bit [31:0] exp_q[$];
    bit        m_err = 0;
    int        m_cnt = 0;
    bit        started = 0;

    always @(posedge clk) begin
        bit ok, acc, popm;
        bit [31:0] w;
        started = 1'b1;
        if (rst) begin
            exp_q.delete();
            m_err = 0;
            m_cnt = 0;
        end else begin
            acc  = in_valid && (exp_q.size() < DEPTH) && !flush;
            popm = out_ready && (exp_q.size() > 0);
            model_encode(in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm, ok, w);
            m_err = acc && !ok;
            if (m_err && m_cnt < 255) m_cnt++;
            if (flush) exp_q.delete();
            else begin
                if (popm) void'(exp_q.pop_front());
                if (acc && ok) exp_q.push_back(w);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("level", 32'(level), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'((exp_q.size() < DEPTH) && !flush));
            chk("err", 32'(err), 32'(m_err));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (exp_q.size() != 0) chk("out_instr", out_instr, exp_q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                         input logic [31:0] imm);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Push one bundle into an empty FIFO, check the word one cycle later, then pop it.
    task automatic send_peek(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                             input logic [31:0] imm, input logic [31:0] exp_w);
        drive(op, f3, 7'd0, rs1, rs2, rd, imm);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk(nm, out_instr, exp_w);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            2: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            3: return $urandom & 32'hFFFFF000;
            4: return $urandom;
            default: return 32'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic rand_bundle();
        logic [6:0] ops [13];
        logic [6:0] op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F,
                7'h17, 7'h37, 7'h07, 7'h27, 7'h53, 7'h73};
        op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 12)];
        in_opcode = op;
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        in_rd  = {($urandom_range(0, 7) == 0) ? 1'($urandom) : ((op == 7'h07) || (op == 7'h53)),
                  5'($urandom)};
        in_rs1 = {($urandom_range(0, 7) == 0) ? 1'($urandom) : (op == 7'h53), 5'($urandom)};
        in_rs2 = {($urandom_range(0, 7) == 0) ? 1'($urandom) : ((op == 7'h27) || (op == 7'h53)),
                  5'($urandom)};
        in_imm = rand_imm();
    endtask

    initial begin
        bit ok;
        bit [31:0] w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        model_encode(7'h13, 3'd0, 7'd0, 6'h00, 6'h00, 6'h01, 32'd5, ok, w);
        chk("model_addi", w, 32'h00500093);
        model_encode(7'h23, 3'd2, 7'd0, 6'h01, 6'h02, 6'h00, 32'd8, ok, w);
        chk("model_sw", w, 32'h0020A423);
        model_encode(7'h6F, 3'd0, 7'd0, 6'h00, 6'h00, 6'h01, 32'h800, ok, w);
        chk("model_jal", w, 32'h001000EF);
        model_encode(7'h63, 3'd0, 7'd0, 6'h01, 6'h02, 6'h00, 32'd3, ok, w);
        chk("model_br_odd_ok", 32'(ok), 32'd0);
        model_encode(7'h53, 3'd0, 7'd0, 6'h21, 6'h22, 6'h01, 32'd0, ok, w);
        chk("model_falu_rd_ok", 32'(ok), 32'd0);

        step();
        send_peek("addi", 7'h13, 3'd0, 6'h00, 6'h00, 6'h01, 32'd5, 32'h00500093);
        send_peek("sw", 7'h23, 3'd2, 6'h01, 6'h02, 6'h00, 32'd8, 32'h0020A423);
        send_peek("jal", 7'h6F, 3'd0, 6'h00, 6'h00, 6'h01, 32'h800, 32'h001000EF);
        send_peek("wfi", 7'h73, 3'd0, 6'h00, 6'h00, 6'h00, 32'h105, 32'h10500073);
        send_peek("mret", 7'h73, 3'd0, 6'h00, 6'h00, 6'h00, 32'h302, 32'h30200073);

        drive(7'h63, 3'd0, 7'd0, 6'h01, 6'h02, 6'h00, 32'd3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("br_err", 32'(err), 32'd1);
        chk("br_err_cnt", 32'(err_cnt), 32'd1);
        chk("br_level", 32'(level), 32'd0);
        step();
        @(negedge clk);
        chk("br_err_once", 32'(err), 32'd0);
        step();

        drive(7'h53, 3'd0, 7'd0, 6'h21, 6'h22, 6'h01, 32'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("falu_err_cnt", 32'(err_cnt), 32'd2);
        step();

        drive(7'h63, 3'd0, 7'd0, 6'h01, 6'h02, 6'h00, 32'd3);
        repeat (300) step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
        step();

        for (int i = 0; i < 5; i++) begin
            drive(7'h13, 3'd0, 7'd0, 6'h01, 6'h00, 6'(i + 1), 32'(i * 3));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_instr, 32'h00008093);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drained_level", 32'(level), 32'd0);
        step();

        for (int i = 0; i < 5; i++) begin
            drive(7'h33, 3'(i), 7'h20, 6'h03, 6'h04, 6'h05, 32'd0);
            if (i == 2) out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_level", 32'(level), 32'd2);
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(7'h37, 3'd0, 7'd0, 6'h00, 6'h00, 6'h07, 32'(i + 1) << 12);
            step();
        end
        flush = 1'b1;
        drive(7'h37, 3'd0, 7'd0, 6'h00, 6'h00, 6'h08, 32'h0000A000);
        @(negedge clk);
        chk("preflush_level", 32'(level), 32'd3);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        step();

        for (int i = 0; i < 2; i++) begin
            drive(7'h13, 3'd0, 7'd0, 6'h02, 6'h00, 6'h03, 32'd7);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        step();

        for (int c = 0; c < 4000; c++) begin
            rand_bundle();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 300) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("final_level", 32'(level), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
